// File: rtl/orao_vram_pkg.sv
// Shared types and default widths for the Orao video RAM arbiter.
package orao_vram_pkg;
  localparam int ADDR_W_DEF       = 13;
  localparam int DATA_W_DEF       = 8;
  localparam int STARVE_LIMIT_DEF = 4;

  typedef enum logic [1:0] {IDLE, CPU_BUSY, ACK} state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_DISP, OWN_CPU} owner_e;
endpackage

// File: rtl/orao_vram_starve_ctr.sv
// Saturating count of consecutive display wins while the CPU waits.
module orao_vram_starve_ctr #(
  parameter int LIMIT = 4
) (
  input  logic clk_pixel,
  input  logic reset_n,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_at_limit
);
  localparam int CW = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n)
      r_cnt <= '0;
    else if (i_clear)
      r_cnt <= '0;
    else if (i_inc && (r_cnt != CW'(LIMIT)))
      r_cnt <= r_cnt + CW'(1);
  end

  assign o_at_limit = (r_cnt == CW'(LIMIT));
endmodule

// File: rtl/orao_vram_arbiter.sv
// Single-port video RAM arbiter: display fetches first, CPU guaranteed a slot by a starvation limit.
// Optional ORAO_VRAM_WRITE_THROUGH_EN: CPU writes to the displayed address update disp_data at issue.
// state    | meaning
// IDLE     | one slot may issue per clock (display or CPU)
// CPU_BUSY | CPU access presented to RAM; ack and read data registered at its end
// ACK      | ack visible; cpu_req here is not a new request
module orao_vram_arbiter
  import orao_vram_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk_pixel,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);
  state_e            r_state;
  state_e            w_state_nxt;
  owner_e            w_owner;
  logic [ADDR_W-1:0] r_disp_addr_q;
  logic [ADDR_W-1:0] r_tag;
  logic              r_disp_pending;
  logic              r_disp_inflight;
  logic              r_cpu_we_q;
  logic              w_at_limit;
  logic              w_wt_hit;

  orao_vram_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk_pixel (clk_pixel),
    .reset_n   (reset_n),
    .i_clear   ((w_owner == OWN_CPU) || ((w_owner == OWN_DISP) && !cpu_req)),
    .i_inc     ((w_owner == OWN_DISP) && cpu_req),
    .o_at_limit(w_at_limit)
  );

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n)
      r_state <= IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:     if (w_owner == OWN_CPU) w_state_nxt = CPU_BUSY;
      CPU_BUSY: w_state_nxt = ACK;
      ACK:      w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  // Slot owner: display unless the waiting CPU has hit the starvation limit.
  always_comb begin
    w_owner = OWN_NONE;
    if (r_state == IDLE) begin
      if (r_disp_pending && !(cpu_req && w_at_limit))
        w_owner = OWN_DISP;
      else if (cpu_req)
        w_owner = OWN_CPU;
    end
  end

`ifdef ORAO_VRAM_WRITE_THROUGH_EN
  assign w_wt_hit = (w_owner == OWN_CPU) && cpu_we && (cpu_addr == r_disp_addr_q);
`else
  assign w_wt_hit = 1'b0;
`endif

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      r_disp_addr_q   <= '0;
      r_disp_pending  <= 1'b1;
      r_disp_inflight <= 1'b0;
      r_tag           <= '0;
      r_cpu_we_q      <= 1'b0;
      ram_addr        <= '0;
      ram_we          <= 1'b0;
      ram_wdata       <= '0;
      disp_data       <= '0;
      cpu_ack         <= 1'b0;
      cpu_rdata       <= '0;
    end else begin
      // A change arriving in an issue cycle keeps the flag set for a refetch.
      if (disp_addr != r_disp_addr_q) begin
        r_disp_addr_q  <= disp_addr;
        r_disp_pending <= 1'b1;
      end else if (w_owner == OWN_DISP) begin
        r_disp_pending <= 1'b0;
      end

      ram_we          <= 1'b0;
      r_disp_inflight <= 1'b0;
      case (w_owner)
        OWN_DISP: begin
          ram_addr        <= r_disp_addr_q;
          r_tag           <= r_disp_addr_q;
          r_disp_inflight <= 1'b1;
        end
        OWN_CPU: begin
          ram_addr   <= cpu_addr;
          ram_we     <= cpu_we;
          ram_wdata  <= cpu_wdata;
          r_cpu_we_q <= cpu_we;
        end
        default: ;
      endcase

      if (w_wt_hit)
        disp_data <= cpu_wdata;
      else if (r_disp_inflight && (r_tag == r_disp_addr_q))
        disp_data <= ram_rdata;

      cpu_ack <= (r_state == CPU_BUSY);
      if ((r_state == CPU_BUSY) && !r_cpu_we_q)
        cpu_rdata <= ram_rdata;
    end
  end
endmodule
